// File: rtl/mackerel_bus_pkg.sv
// Shared types and default timing constants for the mackerel 68000 bus-cycle sequencer.
// The address decoder and the testbench reuse the DEF_* constants.
package mackerel_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_WS  = 3'd1,
        ST_WAIT_DEV = 3'd2,
        ST_ACK      = 3'd3,
        ST_FAULT    = 3'd4,
        ST_END      = 3'd5
    } bus_state_e;

    typedef enum logic [2:0] {
        REG_NONE = 3'd0,
        REG_ROM  = 3'd1,
        REG_RAM  = 3'd2,
        REG_MFP  = 3'd3,
        REG_IACK = 3'd4
    } region_e;

    localparam int DEF_ROM_WS  = 2;
    localparam int DEF_RAM_WS  = 0;
    localparam int DEF_TIMEOUT = 64;
    localparam int DEF_CNT_W   = 8;

    // Memory regions are acknowledged by the wait-state counter, not by a device.
    function automatic logic region_is_mem(input region_e r);
        return (r == REG_ROM) || (r == REG_RAM);
    endfunction

endpackage

// File: rtl/mackerel_bus_region_sel.sv
// Fixed-priority encoder from the active-low decoder selects to a region code:
// ROM > any RAM bank > MFP > IACK > none.
module mackerel_bus_region_sel
    import mackerel_bus_pkg::*;
(
    input  logic       rom_en_n,
    input  logic [3:0] ram_en_n,
    input  logic       mfp_en_n,
    input  logic       iack_n,
    output logic [2:0] region
);

    region_e region_s;

    // Priority resolution; overlapping selects are legal and never an error.
    always_comb begin
        region_s = REG_NONE;
        if (!rom_en_n) begin
            region_s = REG_ROM;
        end else if (ram_en_n != 4'hF) begin
            region_s = REG_RAM;
        end else if (!mfp_en_n) begin
            region_s = REG_MFP;
        end else if (!iack_n) begin
            region_s = REG_IACK;
        end else begin
            region_s = REG_NONE;
        end
    end

    assign region = region_s;

endmodule

// File: rtl/mackerel_bus_ctrl.sv
// 68000 bus-cycle sequencer: wait-state DTACK, MFP DTACK forwarding and a BERR watchdog.
// Optional build macro MACKEREL_AUTOVEC_EN: IACK timeouts answer with VPA instead of BERR.
module mackerel_bus_ctrl
    import mackerel_bus_pkg::*;
#(
    parameter int ROM_WS  = DEF_ROM_WS,
    parameter int RAM_WS  = DEF_RAM_WS,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       AS,
    input  logic       ROMEN,
    input  logic [3:0] RAMEN,
    input  logic       MFPEN,
    input  logic       IACK,
    input  logic       DTACK_MFP,
    output logic       DTACK,
    output logic       BERR,
    output logic       VPA,
    output logic       TIMEOUT_EVT
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ROM_WS_C  = CNT_W'(ROM_WS);
    localparam logic [CNT_W-1:0] RAM_WS_C  = CNT_W'(RAM_WS);
    localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    bus_state_e       state_q, state_d;
    region_e          region_q, region_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dtack_q, dtack_d;
    logic             berr_q, berr_d;
    logic             vpa_q, vpa_d;
    logic             evt_q, evt_d;

    logic [2:0]       region_sel_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [CNT_W-1:0] ws_s;
    logic             fault_vpa_s;
    logic             dev_ack_s;

    mackerel_bus_region_sel u_region_sel (
        .rom_en_n (ROMEN),
        .ram_en_n (RAMEN),
        .mfp_en_n (MFPEN),
        .iack_n   (IACK),
        .region   (region_sel_s)
    );

`ifdef MACKEREL_AUTOVEC_EN
    assign fault_vpa_s = (region_q == REG_IACK);
`else
    assign fault_vpa_s = 1'b0;
`endif

    assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    assign ws_s      = (region_q == REG_ROM) ? ROM_WS_C : RAM_WS_C;
    assign dev_ack_s = !DTACK_MFP && ((region_q == REG_MFP) || (region_q == REG_IACK));

    // Next-state, counter and registered-strobe computation; abort (AS high) wins over any response.
    always_comb begin
        state_d  = state_q;
        region_d = region_q;
        cnt_d    = cnt_q;
        dtack_d  = 1'b1;
        berr_d   = 1'b1;
        vpa_d    = 1'b1;
        evt_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!AS) begin
                    region_d = region_e'(region_sel_s);
                    cnt_d    = '0;
                    state_d  = region_is_mem(region_e'(region_sel_s)) ? ST_WAIT_WS : ST_WAIT_DEV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_WS: begin
                if (AS) begin
                    state_d = ST_END;
                end else if (cnt_q == ws_s) begin
                    state_d = ST_ACK;
                    dtack_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ST_WAIT_DEV: begin
                if (AS) begin
                    state_d = ST_END;
                end else if (dev_ack_s) begin
                    state_d = ST_ACK;
                    dtack_d = 1'b0;
                end else if (cnt_q == TO_LAST_C) begin
                    state_d = ST_FAULT;
                    berr_d  = fault_vpa_s;
                    vpa_d   = !fault_vpa_s;
                    evt_d   = !fault_vpa_s;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ST_ACK: begin
                if (AS) begin
                    state_d = ST_END;
                end else begin
                    dtack_d = 1'b0;
                end
            end
            ST_FAULT: begin
                if (AS) begin
                    state_d = ST_END;
                end else begin
                    berr_d = fault_vpa_s;
                    vpa_d  = !fault_vpa_s;
                end
            end
            ST_END: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            region_q <= REG_NONE;
            cnt_q    <= '0;
            dtack_q  <= 1'b1;
            berr_q   <= 1'b1;
            vpa_q    <= 1'b1;
            evt_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            region_q <= region_d;
            cnt_q    <= cnt_d;
            dtack_q  <= dtack_d;
            berr_q   <= berr_d;
            vpa_q    <= vpa_d;
            evt_q    <= evt_d;
        end
    end

    assign DTACK       = dtack_q;
    assign BERR        = berr_q;
    assign VPA         = vpa_q;
    assign TIMEOUT_EVT = evt_q;

endmodule

// File: doc/mackerel_bus_ctrl.md
Name: mackerel_bus_ctrl

Overview:
- Bus-cycle sequencer for the 68000 local bus. It sits behind the address decoder and consumes its chip enables (ROM, RAM banks, MFP) and the IACK decode.
- Generates CPU DTACK with per-region programmable wait states and forwards the MFP's own DTACK.
- A watchdog asserts BERR when no device responds.
- Replaces the purely combinational DTACK path so that slow ROM and unmapped accesses cannot hang the CPU.

Parameters:
- ROM_WS, 2, wait states (CLK cycles) inserted before DTACK for ROM cycles; 0..15
- RAM_WS, 0, wait states before DTACK for any RAM bank; 0..15
- TIMEOUT, 64, CLK cycles from cycle start to BERR when no DTACK is produced; 2..255
- CNT_W, 8, width of the shared cycle counter; must hold max(ROM_WS, RAM_WS, TIMEOUT)

Ports:
- CLK  in  1  CPU clock
- RST  in  1  synchronous reset, active-low
- AS  in  1  CPU address strobe, active-low
- ROMEN  in  1  ROM select from decoder, active-low
- RAMEN  in  4  RAM bank selects RAMEN0..3, active-low
- MFPEN  in  1  MFP select, active-low
- IACK  in  1  interrupt-acknowledge decode (FC=111), active-low
- DTACK_MFP  in  1  MFP data acknowledge, active-low
- DTACK  out  1  data acknowledge to CPU, active-low
- BERR  out  1  bus error to CPU, active-low
- VPA  out  1  valid peripheral address (autovector), active-low; tied high without the optional feature
- TIMEOUT_EVT  out  1  one-CLK high pulse when a timeout fires

Behaviour:
- Reset (RST=0 at posedge): state=IDLE, counter=0, DTACK=1, BERR=1, VPA=1, TIMEOUT_EVT=0. Reset mid-cycle releases all strobes on the next edge; the CPU cycle is abandoned.
- All inputs are sampled at posedge CLK. Outputs are registered with no combinational input-to-output paths.
- States: IDLE, WAIT_WS, WAIT_DEV, ACK, FAULT, END.
- IDLE: on AS=0, latch the region by fixed priority ROM > RAM (any bank) > MFP > IACK > none. Clear the counter.
  - ROM/RAM -> WAIT_WS.
  - MFP or IACK -> WAIT_DEV.
  - none -> WAIT_DEV (timeout path only).
- WAIT_WS: counter increments each cycle. When counter == WS for the latched region, go to ACK.
  - WS=0: DTACK low on the first edge after AS is sampled low (1-cycle latency).
  - WS=n: DTACK low n cycles later.
- WAIT_DEV: counter increments. DTACK_MFP=0 with region MFP or IACK -> ACK. Counter == TIMEOUT-1 -> FAULT.
- ACK: DTACK=0. Hold until AS=1, then -> END.
- FAULT: BERR=0. TIMEOUT_EVT=1 for the first cycle only. Hold until AS=1, then -> END.
- END: DTACK, BERR and VPA return to 1. -> IDLE. This guarantees at least one released cycle between bus cycles.
- AS=1 in WAIT_WS or WAIT_DEV (aborted cycle): -> END immediately with no strobe asserted.
- Multiple enables low at once: resolved by priority, never an error. Enables are only sampled in IDLE; later changes are ignored.
- The counter saturates at its maximum value and never wraps.
- DTACK and BERR are never low simultaneously.

Optional Feature:
- Macro: MACKEREL_AUTOVEC_EN.
- Defined: an IACK cycle reaching timeout asserts VPA=0 instead of BERR, with TIMEOUT_EVT=0. VPA holds until AS=1 (CPU autovectors). A device DTACK_MFP=0 before timeout still gives a normal DTACK.
- Undefined: VPA is constant 1, and IACK timeouts produce BERR like any other timeout.

Decomposition:
- Shared package mackerel_bus_pkg:
  - state enum
  - region enum (REG_NONE, REG_ROM, REG_RAM, REG_MFP, REG_IACK)
  - default wait-state and timeout constants, reused by the decoder and the testbench.
- One natural sub-module, mackerel_bus_region_sel: combinational priority encoder from the enables and IACK to the region code. The FSM, counter and outputs stay in the top.

Test Plan:
- ROM_WS=2, ROMEN=0, AS falls at edge 0 -> DTACK=0 at edge 3, released one edge after AS=1.
- RAM_WS=0, RAMEN[2]=0 -> DTACK=0 at edge 1. Back-to-back cycles -> DTACK=1 for at least one cycle between them.
- MFPEN=0, DTACK_MFP falls 5 cycles after AS -> DTACK=0 one edge later, BERR stays 1.
- No enable, AS held low, TIMEOUT=64 -> BERR=0 at edge 64 and TIMEOUT_EVT high for exactly one cycle; DTACK stays 1.
- IACK=0, no DTACK_MFP -> with MACKEREL_AUTOVEC_EN, VPA=0 at timeout and BERR=1; without it, BERR=0 and VPA=1.
- RST=0 during WAIT_WS, and AS rising during WAIT_DEV -> all outputs 1 next edge, state IDLE, next cycle behaves normally.
